// File: rtl/servo_pkg.sv
// Shared definitions for the two-axis galvo servo sequencer: state encoding,
// axis select values and sample width.
package servo_pkg;

  localparam int DATA_W = 16;

  localparam logic AXIS_X = 1'b0;
  localparam logic AXIS_Y = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CONV  = 3'd1;
  localparam logic [2:0] ST_PID_X = 3'd2;
  localparam logic [2:0] ST_PID_Y = 3'd3;
  localparam logic [2:0] ST_DAC   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CONV  = ST_CONV,
    PID_X = ST_PID_X,
    PID_Y = ST_PID_Y,
    DAC   = ST_DAC
  } state_t;

endpackage

// File: rtl/servo_tick_gen.sv
// Sample-period counter: runs 0..PERIOD_CYC-1 while enabled and flags the wrap
// cycle as tick; dropping enable parks the counter at 0.
module servo_tick_gen #(
  parameter int PERIOD_CYC = 200
) (
  input  logic clk_ref,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_ref) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/servo_loop_sched.sv
// Per-sample sequencer: triggers both position ADCs, time-shares one PID engine
// between X and Y, then writes both results to the DACs via req/ack.
module servo_loop_sched
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC  = 200,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk_ref,
  input  logic                     reset,
  input  logic                     enable,
  output logic                     adc_start,
  input  logic                     x_pos_valid,
  input  logic                     y_pos_valid,
  input  logic signed [DATA_W-1:0] x_pos,
  input  logic signed [DATA_W-1:0] y_pos,
  output logic                     pid_start,
  output logic                     pid_axis,
  output logic signed [DATA_W-1:0] pid_pos,
  input  logic                     pid_done,
  input  logic signed [DATA_W-1:0] pid_out,
  output logic                     x_dac_req,
  output logic                     y_dac_req,
  output logic signed [DATA_W-1:0] x_dac_data,
  output logic signed [DATA_W-1:0] y_dac_data,
  input  logic                     x_dac_ack,
  input  logic                     y_dac_ack,
  output logic                     busy,
  output logic                     overrun,
  output logic                     adc_timeout
);

  logic tick;

  servo_tick_gen #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
    .clk_ref (clk_ref),
    .reset   (reset),
    .enable  (enable),
    .tick    (tick)
  );

  state_t                     state, state_n;
  logic                       x_got, x_got_n, y_got, y_got_n;
  logic signed [DATA_W-1:0]   x_smp, x_smp_n, y_smp, y_smp_n;
  logic [7:0]                 to_cnt, to_cnt_n;
  logic [8:0]                 to_inc;
  logic                       adc_start_n, pid_start_n, pid_axis_n;
  logic signed [DATA_W-1:0]   pid_pos_n, x_dac_data_n, y_dac_data_n;
  logic                       x_dac_req_n, y_dac_req_n;
  logic                       busy_n, overrun_n, adc_timeout_n;

  // The adc_start cycle already counts as the first CONV cycle.
  assign to_inc = {1'b0, to_cnt} + 9'd1;

  always_comb begin
    state_n       = state;
    x_got_n       = x_got;
    y_got_n       = y_got;
    x_smp_n       = x_smp;
    y_smp_n       = y_smp;
    to_cnt_n      = to_cnt;
    adc_start_n   = 1'b0;
    pid_start_n   = 1'b0;
    pid_axis_n    = pid_axis;
    pid_pos_n     = pid_pos;
    x_dac_req_n   = x_dac_req;
    y_dac_req_n   = y_dac_req;
    x_dac_data_n  = x_dac_data;
    y_dac_data_n  = y_dac_data;
    overrun_n     = 1'b0;
    adc_timeout_n = 1'b0;

    case (state)
      IDLE: begin
        if (tick) begin
          state_n     = CONV;
          adc_start_n = 1'b1;
          x_got_n     = 1'b0;
          y_got_n     = 1'b0;
          to_cnt_n    = '0;
        end
      end
      CONV: begin
        to_cnt_n = to_inc[7:0];
        if (x_pos_valid) begin
          x_smp_n = x_pos;
          x_got_n = 1'b1;
        end
        if (y_pos_valid) begin
          y_smp_n = y_pos;
          y_got_n = 1'b1;
        end
        // Completed data takes priority over a timeout expiring this cycle.
        if (x_got_n && y_got_n) begin
          state_n     = PID_X;
          pid_start_n = 1'b1;
          pid_axis_n  = AXIS_X;
          pid_pos_n   = x_smp_n;
        end else if (to_inc == 9'(TIMEOUT_CYC)) begin
          state_n       = IDLE;
          adc_timeout_n = 1'b1;
        end
      end
      PID_X: begin
        if (pid_done) begin
          x_dac_data_n = pid_out;
          state_n      = PID_Y;
          pid_start_n  = 1'b1;
          pid_axis_n   = AXIS_Y;
          pid_pos_n    = y_smp;
        end
      end
      PID_Y: begin
        if (pid_done) begin
          y_dac_data_n = pid_out;
          state_n      = DAC;
          x_dac_req_n  = 1'b1;
          y_dac_req_n  = 1'b1;
        end
      end
      DAC: begin
        x_dac_req_n = x_dac_req && !x_dac_ack;
        y_dac_req_n = y_dac_req && !y_dac_ack;
        if (!x_dac_req_n && !y_dac_req_n) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (tick && (state != IDLE)) begin
      overrun_n = 1'b1;
    end
    busy_n = (state_n != IDLE);
  end

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge clk_ref) begin
    if (reset) begin
      state       <= IDLE;
      x_got       <= 1'b0;
      y_got       <= 1'b0;
      x_smp       <= '0;
      y_smp       <= '0;
      to_cnt      <= '0;
      adc_start   <= 1'b0;
      pid_start   <= 1'b0;
      pid_axis    <= AXIS_X;
      pid_pos     <= '0;
      x_dac_req   <= 1'b0;
      y_dac_req   <= 1'b0;
      x_dac_data  <= '0;
      y_dac_data  <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      adc_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      x_got       <= x_got_n;
      y_got       <= y_got_n;
      x_smp       <= x_smp_n;
      y_smp       <= y_smp_n;
      to_cnt      <= to_cnt_n;
      adc_start   <= adc_start_n;
      pid_start   <= pid_start_n;
      pid_axis    <= pid_axis_n;
      pid_pos     <= pid_pos_n;
      x_dac_req   <= x_dac_req_n;
      y_dac_req   <= y_dac_req_n;
      x_dac_data  <= x_dac_data_n;
      y_dac_data  <= y_dac_data_n;
      busy        <= busy_n;
      overrun     <= overrun_n;
      adc_timeout <= adc_timeout_n;
    end
  end

endmodule

// File: doc/servo_loop_sched.md
# servo_loop_sched

Per-sample sequencer for the two-axis galvo servo loop. Each sample period it triggers both position ADCs, collects the readings, and time-shares one PID engine between the X and Y axes. It then hands both results to the X and Y DAC interfaces through a req/ack handshake. It sits between the position-ADC interfaces, the shared PID engine and the DAC interfaces, in the 20 MHz domain.

## Interface
Parameters:
- PERIOD_CYC, 200, sample period in clk_ref cycles (100 kHz at 20 MHz); legal range 16..65535
- TIMEOUT_CYC, 64, max cycles in CONV waiting for ADC data; legal range 1..255

Ports:
- clk_ref  in  1  20 MHz system clock; the only clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  loop enable; low stops new sample ticks
- adc_start  out  1  one-cycle pulse starting conversion on both position ADCs
- x_pos_valid / y_pos_valid  in  1  one-cycle strobe, position sample ready
- x_pos / y_pos  in  16  position sample, two's complement, valid with strobe
- pid_start  out  1  one-cycle pulse launching the PID engine
- pid_axis  out  1  axis select; 0 = X, 1 = Y; held until pid_done
- pid_pos  out  16  position fed to PID; held until pid_done
- pid_done  in  1  one-cycle strobe, pid_out valid
- pid_out  in  16  PID result
- x_dac_req / y_dac_req  out  1  DAC write request (level)
- x_dac_data / y_dac_data  out  16  DAC code; stable while req is high
- x_dac_ack / y_dac_ack  in  1  one-cycle strobe, DAC write accepted
- busy  out  1  high in any state other than IDLE
- overrun  out  1  one-cycle pulse when a tick arrives while busy
- adc_timeout  out  1  one-cycle pulse when CONV times out

## Operation
- Period counter runs 0..PERIOD_CYC-1 while enable is high and wraps. `tick` fires on the wrap.
- enable low clears the counter to 0 and suppresses ticks. A sequence already in progress completes normally.
- State machine states: IDLE, CONV, PID_X, PID_Y, DAC.
- IDLE:
  - On tick: go to CONV, pulse adc_start, clear x_got and y_got, clear the timeout counter.
- CONV:
  - Each pos_valid captures its sample and sets its got flag. Strobes may arrive in either order or in the same cycle.
  - A repeat strobe overwrites the captured sample.
  - Both got flags set: go to PID_X.
  - Timeout counter reaches TIMEOUT_CYC: pulse adc_timeout, go to IDLE. The DACs are not updated.
- PID_X:
  - On entry, pulse pid_start with pid_axis=0 and pid_pos=x sample.
  - On pid_done, capture pid_out into x_dac_data and go to PID_Y.
- PID_Y:
  - Same as PID_X with pid_axis=1 and the y sample.
  - On pid_done, capture pid_out into y_dac_data and go to DAC.
- DAC:
  - Both reqs rise on entry.
  - Each req drops the cycle after its ack. An ack with req low is ignored.
  - Both acked: go to IDLE.
- A tick in any state other than IDLE is dropped and pulses overrun. The counter keeps running.
- Simultaneous tick and return to IDLE: the state is not IDLE in that cycle, so it counts as an overrun.
- No PID or DAC timeout. Those engines are guaranteed to respond.

## Timing
- Reset values:
  - State IDLE; counter 0.
  - adc_start, pid_start, pid_axis, x_dac_req, y_dac_req, busy, overrun, adc_timeout all 0.
  - pid_pos, x_dac_data, y_dac_data 0x0000.
- Reset during any state returns to IDLE next cycle. All reqs drop and any pending handshake is abandoned.
- Event latencies:
  - tick in cycle N → adc_start high in N+1.
  - Second pos_valid in cycle M → pid_start (X) in M+1.
  - X pid_done in cycle P → pid_start (Y) in P+1.
  - Y pid_done in cycle Q → both reqs high in Q+1.
  - Last ack in cycle A → state IDLE and busy low in A+1.
- Timeout: the counter increments each CONV cycle starting at the adc_start cycle. adc_timeout pulses in the cycle the count equals TIMEOUT_CYC if data is incomplete.
- Valid strobes arriving in the same cycle as timeout expiry still complete CONV; data wins over timeout.
- All outputs are registered.

## Structure
- Shared package servo_pkg:
  - state encoding (localparam, 3 bits)
  - AXIS_X=0 and AXIS_Y=1
  - data width 16
- One sub-module: servo_tick_gen (period counter with enable, tick output). The FSM and capture registers stay in servo_loop_sched.

## Test plan
- PERIOD_CYC=40, enable high, x_pos=0x1234, y_pos=0xFEDC returned 5 cycles after adc_start, PID stub returns pos+1 after 3 cycles → pid_pos 0x1234 then 0xFEDC; x_dac_data=0x1235, y_dac_data=0xFEDD; next adc_start exactly 40 cycles after the previous one.
- Only x_pos_valid given, TIMEOUT_CYC=8 → adc_timeout pulses once, no pid_start, no dac_req, back to IDLE; the next tick restarts normally.
- y_dac_ack withheld for 60 cycles with PERIOD_CYC=40 → overrun pulses once; x_dac_req drops after its ack; y_dac_req stays high until its ack.
- Both pos_valid in the same cycle as timeout expiry → no adc_timeout; pid_start(X) in the next cycle.
- reset asserted mid-PID_Y → next cycle IDLE, all outputs at reset values; first adc_start comes PERIOD_CYC cycles after reset release.
- enable dropped during DAC → sequence completes; no further adc_start until enable returns, then the first adc_start comes PERIOD_CYC cycles later.
